// File: rtl/window_ones_counter.sv
`default_nettype none
// ============================================================================
// Module   : window_ones_counter
// Brief    : Splits each start-edge-triggered frame into n windows and emits
//            the ones count of every window as a strobed W-bit word.
// Revision : 1.0
// ============================================================================
module window_ones_counter #(
  parameter int SAMPLES = 2,
  parameter int OSF     = 8,
  parameter int n       = 3
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             SampleEn,
  input  logic                             Enable,
  input  logic                             LineIn,
  output logic [$clog2(SAMPLES*OSF):0]     CountOut,
  output logic                             CountValid,
  output logic                             FrameDone,
  output logic                             Busy
);

  localparam int W  = $clog2(SAMPLES*OSF) + 1;
  localparam int WI = $clog2(n) + 1;
  localparam logic [W-1:0]  c_LAST_SAMPLE = W'(SAMPLES*OSF - 1);
  localparam logic [WI-1:0] c_LAST_WIN    = WI'(n - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_line_s;
  logic          r_prev_s;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_sample_idx;
  logic [WI-1:0] r_win_idx;
  logic [W-1:0]  r_count_out;
  logic          r_count_valid;
  logic          r_frame_done;
  logic          r_busy;
  logic [W-1:0]  w_acc_next;

  assign w_acc_next = r_acc + {{(W-1){1'b0}}, r_line_s};

  // Synchronizer presets to the idle level so reset never fakes a start edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1  <= 1'b1;
      r_line_s <= 1'b1;
    end else begin
      r_sync1  <= LineIn;
      r_line_s <= r_sync1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_prev_s      <= 1'b1;
      r_acc         <= '0;
      r_sample_idx  <= '0;
      r_win_idx     <= '0;
      r_count_out   <= '0;
      r_count_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      if (SampleEn) begin
        r_prev_s <= r_line_s;
      end
      case (r_state)
        S_IDLE: begin
          // The start sample itself is sample 0 of window 0 and is known low
          if (SampleEn && Enable && r_prev_s && !r_line_s) begin
            r_state      <= S_COUNT;
            r_busy       <= 1'b1;
            r_acc        <= '0;
            r_sample_idx <= W'(1);
            r_win_idx    <= '0;
          end
        end
        S_COUNT: begin
          if (!Enable) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_acc        <= '0;
            r_sample_idx <= '0;
            r_win_idx    <= '0;
          end else if (SampleEn) begin
            if (r_sample_idx == c_LAST_SAMPLE) begin
              r_count_out   <= w_acc_next;
              r_count_valid <= 1'b1;
              r_acc         <= '0;
              r_sample_idx  <= '0;
              if (r_win_idx == c_LAST_WIN) begin
                r_frame_done <= 1'b1;
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                r_win_idx    <= '0;
              end else begin
                r_win_idx <= r_win_idx + WI'(1);
              end
            end else begin
              r_acc        <= w_acc_next;
              r_sample_idx <= r_sample_idx + W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign CountOut   = r_count_out;
  assign CountValid = r_count_valid;
  assign FrameDone  = r_frame_done;
  assign Busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_window_ones_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_ones_counter
// Brief    : Scoreboard bench for window_ones_counter at default parameters.
// Revision : 1.0
// ============================================================================
module tb_window_ones_counter;

  logic       Clk;
  logic       Reset;
  logic       SampleEn;
  logic       Enable;
  logic       LineIn;
  logic [4:0] CountOut;
  logic       CountValid;
  logic       FrameDone;
  logic       Busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sb[$];
  int strobe_cyc[$];
  logic [14:0] shreg = '0;

  window_ones_counter #(.SAMPLES(2), .OSF(8), .n(3)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .SampleEn   (SampleEn),
    .Enable     (Enable),
    .LineIn     (LineIn),
    .CountOut   (CountOut),
    .CountValid (CountValid),
    .FrameDone  (FrameDone),
    .Busy       (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Models the downstream 3-word shift stage, oldest word most significant
  always @(posedge Clk) if (CountValid) shreg <= {shreg[9:0], CountOut};

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge Clk) begin
    #1;
    if (CountValid) begin
      int e;
      strobe_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("strobe_unexpected", int'(CountValid), 0);
      end else begin
        e = sb.pop_front();
        check("count", int'(CountOut), e & 31);
        check("framedone", int'(FrameDone), (e >> 8) & 1);
        check("busy_at_strobe", int'(Busy), ((e >> 8) & 1) ? 0 : 1);
      end
    end else if (FrameDone) begin
      check("fd_without_cv", int'(CountValid), 1);
    end
  end

  task automatic tick(input logic v, input int per);
    for (int i = 0; i < per; i++) begin
      @(negedge Clk);
      LineIn   = v;
      SampleEn = (i == per - 1);
    end
  endtask

  task automatic quiet(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge Clk);
      SampleEn = 1'b0;
    end
  endtask

  task automatic push_windows(input logic [47:0] pat, input int nw);
    for (int w = 0; w < nw; w++) begin
      int c;
      c = 0;
      for (int j = 0; j < 16; j++) c += int'(pat[w*16 + j]);
      sb.push_back(c | ((w == 2) ? 256 : 0));
    end
  endtask

  task automatic send_frame(input logic [47:0] pat, input int per);
    for (int i = 0; i < 48; i++) begin
      tick(pat[i], per);
      if (i == 10) check("busy_mid_frame", int'(Busy), 1);
    end
  endtask

  logic [47:0] pat_low, pat_mix, pat_high;

  initial begin
    pat_low  = '0;
    pat_high = {47'h7FFF_FFFF_FFFF, 1'b0};
    for (int i = 0; i < 48; i++)
      pat_mix[i] = (i < 16) ? 1'b0 : (i < 32) ? 1'b1 : ((i % 2) == 0);

    Reset = 1'b1; Enable = 1'b1; LineIn = 1'b1; SampleEn = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check("rst_countout", int'(CountOut), 0);
    check("rst_countvalid", int'(CountValid), 0);
    check("rst_framedone", int'(FrameDone), 0);
    check("rst_busy", int'(Busy), 0);

    // Idle line: nothing should happen
    for (int i = 0; i < 50; i++) tick(1'b1, 4);
    check("idle_busy", int'(Busy), 0);
    check("idle_countout", int'(CountOut), 0);
    check("idle_strobes", strobe_cyc.size(), 0);

    // All-low frame, strobes 64 Clk apart
    strobe_cyc.delete();
    push_windows(pat_low, 3);
    send_frame(pat_low, 4);
    for (int i = 0; i < 6; i++) tick(1'b1, 4);
    check("low_strobes", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check("low_gap0", strobe_cyc[1] - strobe_cyc[0], 64);
      check("low_gap1", strobe_cyc[2] - strobe_cyc[1], 64);
    end

    // Mixed frame: 0, 16, 8
    push_windows(pat_mix, 3);
    send_frame(pat_mix, 4);
    for (int i = 0; i < 6; i++) tick(1'b1, 4);
    check("shift_stage", int'(shreg), (0 << 10) | (16 << 5) | 8);

    // Enable abort at sample 20
    push_windows(pat_low, 1);
    for (int i = 0; i < 20; i++) tick(1'b0, 4);
    @(negedge Clk);
    Enable = 1'b0; SampleEn = 1'b0; LineIn = 1'b0;
    @(posedge Clk); #1;
    check("abort_busy", int'(Busy), 0);
    strobe_cyc.delete();
    for (int i = 0; i < 12; i++) tick(1'b0, 4);
    for (int i = 0; i < 4; i++) tick(1'b1, 4);
    check("abort_strobes", strobe_cyc.size(), 0);
    check("abort_countout", int'(CountOut), 0);
    Enable = 1'b1;
    push_windows(pat_high, 3);
    send_frame(pat_high, 4);
    for (int i = 0; i < 6; i++) tick(1'b1, 4);

    // Reset at sample 30 of a mixed frame
    push_windows(pat_mix, 1);
    for (int i = 0; i < 30; i++) tick(pat_mix[i], 4);
    @(negedge Clk);
    Reset = 1'b1; SampleEn = 1'b0; LineIn = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("midrst_countout", int'(CountOut), 0);
    check("midrst_countvalid", int'(CountValid), 0);
    check("midrst_framedone", int'(FrameDone), 0);
    check("midrst_busy", int'(Busy), 0);
    check("midrst_sb", sb.size(), 0);
    for (int i = 0; i < 4; i++) tick(1'b1, 4);
    push_windows(pat_mix, 3);
    send_frame(pat_mix, 4);
    for (int i = 0; i < 6; i++) tick(1'b1, 4);

    // Glitch of 2 Clk between sampling ticks
    strobe_cyc.delete();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge Clk);
        LineIn   = (i == 2 || i == 3) ? 1'b0 : 1'b1;
        SampleEn = (i == 3);
      end
      @(posedge Clk); #1;
      if (k == 4) check("glitch_busy", int'(Busy), 0);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 4);
    check("glitch_strobes", strobe_cyc.size(), 0);

    // SampleEn tied high, back-to-back frames with one high sample between
    strobe_cyc.delete();
    for (int i = 0; i < 4; i++) tick(1'b1, 1);
    push_windows(pat_mix, 3);
    push_windows(pat_high, 3);
    send_frame(pat_mix, 1);
    tick(1'b1, 1);
    send_frame(pat_high, 1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1);
    quiet(4);
    check("fast_strobes", strobe_cyc.size(), 6);
    check("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/window_ones_counter.md
Name: window_ones_counter

Overview:
Upstream stage of the n-word count shift register. It samples the serial line at the oversampling tick and, after a falling start edge, splits the frame into n windows of SAMPLES*OSF samples each. For each window it counts the samples that were high and emits that count as one W-bit word with a one-cycle strobe. The strobe is the shift enable for the downstream n-word shift stage, so that stage holds windows 0..n-1 after each frame.

Parameters:
SAMPLES, 2, bit periods per window
OSF, 8, oversampling factor (samples per bit period)
n, 3, windows per frame; equals the word count of the downstream shift stage
W (localparam), $clog2(SAMPLES*OSF)+1, count word width; holds 0..SAMPLES*OSF inclusive (5 bits at defaults)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
SampleEn  input  1  oversampling tick, one Clk cycle wide
Enable  input  1  arms start detection; low aborts a frame in progress
LineIn  input  1  asynchronous serial line; idles high
CountOut  output  W  ones count of the last completed window
CountValid  output  1  one-cycle strobe: CountOut updated this cycle
FrameDone  output  1  one-cycle strobe, coincident with the CountValid of window n-1
Busy  output  1  high while in COUNT

Behaviour:
- Input synchronizer:
  - LineIn passes through a 2-flop synchronizer clocked every Clk, giving line_s.
  - All sampling uses line_s in cycles where SampleEn=1.
  - prev_s register is updated with line_s on every SampleEn, in every state.
- Reset:
  - state=IDLE.
  - CountOut=0, CountValid=0, FrameDone=0, Busy=0.
  - Accumulator, sample counter and window counter cleared.
  - Synchronizer flops and prev_s set to 1, so no false start edge after reset.
- IDLE, Busy=0:
  - Start condition: SampleEn=1, Enable=1, prev_s=1 and line_s=0.
  - On start: go to COUNT. The start sample is sample 0 of window 0: acc<=0 (line_s=0), sample_idx<=1, win_idx<=0.
- COUNT, Busy=1. On each SampleEn:
  - acc<=acc+line_s and sample_idx<=sample_idx+1.
  - When sample_idx==SAMPLES*OSF-1 (last sample of the window):
    - CountOut<=acc+line_s; CountValid=1 on the next cycle for exactly one cycle.
    - acc<=0, sample_idx<=0, win_idx<=win_idx+1.
  - If win_idx==n-1 at that point:
    - FrameDone=1 in the same cycle as that CountValid.
    - State returns to IDLE in that cycle.
- Latency:
  - CountValid occurs 1 Clk after the SampleEn of the window's last sample.
  - Sampling lags LineIn by 2 Clk (synchronizer).
- Enable=0 in COUNT: go to IDLE on the next Clk.
  - Partial window is discarded: no CountValid, CountOut unchanged, counters cleared.
  - This holds even if that cycle carries the last SampleEn of a window.
- Reset mid-COUNT overrides everything: reset values are restored in the next cycle and no strobe is emitted.
- CountOut holds its value between strobes and is never cleared except by Reset.
- Arithmetic:
  - acc is W bits and cannot overflow; maximum is SAMPLES*OSF.
  - win_idx is $clog2(n)+1 bits.
- SampleEn=0 cycles change no state other than the synchronizer.
- Frame restart: a new frame needs a new 1->0 transition between consecutive SampleEn samples after returning to IDLE. A line still low at frame end does not restart.
- Glitch rejection: a LineIn pulse that starts and ends between two SampleEn ticks is invisible.
- SampleEn may be high every cycle; behaviour is identical with one sample per Clk.

Test Plan:
(Defaults SAMPLES=2, OSF=8, n=3. SampleEn every 4 Clk unless stated.)
1. Reset 3 cycles, LineIn=1, Enable=1 for 200 cycles -> CountValid, FrameDone and Busy stay 0; CountOut=0.
2. LineIn 1->0, then held low for 48 samples -> three CountValid pulses 64 Clk apart with CountOut=0,0,0. FrameDone coincides with the third; Busy drops the same cycle.
3. Start edge, then low for samples 0-15, high for 16-31, alternating 1/0 for 32-47 -> CountOut=0, then 16, then 8; FrameDone with the 8. Downstream shift stage then reads {0,16,8}, oldest word most significant.
4. Enable deasserted at sample 20 of a frame -> Busy=0 next Clk, no further CountValid, CountOut stays 0 (window 0 value). Re-enable, new edge, all-high after start -> counts 15,16,16.
5. Reset asserted at sample 30 -> all outputs 0 next cycle, no strobe. A fresh frame afterwards behaves as scenario 3.
6. SampleEn tied high; a 2-Clk low LineIn glitch while SampleEn every 4 Clk does not start a frame. With SampleEn tied high, two back-to-back frames separated by 1 high sample both complete with correct counts.
